// File: rtl/pcs_40g_tx_sched.sv
// 40GBASE-R PCS TX slot scheduler: picks data, AM or gearbox stall per cycle.
// Optional debug counters and one-hot assertion under PCS_SCHED_DBG_EN.
module pcs_40g_tx_sched #(
  parameter int AM_PERIOD = 16383,
  parameter int GB_PERIOD = 32,
  parameter int AM_CNT_W  = $clog2(AM_PERIOD),
  parameter int GB_CNT_W  = $clog2(GB_PERIOD)
) (
  input  logic clk,
  input  logic nreset,
  input  logic en_i,
  output logic ready_o,
  output logic blk_v_o,
  output logic am_v_o,
  output logic gb_stall_o
`ifdef PCS_SCHED_DBG_EN
  ,
  output logic [31:0] am_sent_o,
  output logic [31:0] gb_slip_o
`endif
);

  localparam logic [1:0] S_INIT  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_AM    = 2'd2;
  localparam logic [1:0] S_STALL = 2'd3;

  logic [1:0]          state_q, state_d;
  logic [AM_CNT_W-1:0] am_cnt_q, am_cnt_d;
  logic [GB_CNT_W-1:0] gb_cnt_q, gb_cnt_d;
  logic                am_pend_q, am_pend_d;
  logic                blk_q, am_q, stall_q;
  logic                stall_due, am_wrap, gb_wrap;

  assign am_wrap = am_cnt_q == AM_CNT_W'(AM_PERIOD - 1);
  assign gb_wrap = gb_cnt_q == GB_CNT_W'(GB_PERIOD - 1);

  // gb_cnt only sits at 0 after a block slot if that block wrapped it
  assign stall_due = (state_q == S_RUN || state_q == S_AM) &&
                     gb_cnt_q == '0;

  always_comb begin
    state_d   = S_RUN;
    am_cnt_d  = am_cnt_q;
    gb_cnt_d  = gb_cnt_q;
    am_pend_d = am_pend_q;
    if (state_q == S_INIT)
      state_d = S_AM;
    else if (stall_due)
      state_d = S_STALL;
    else if (am_pend_q)
      state_d = S_AM;
    if (state_d != S_STALL)
      gb_cnt_d = gb_wrap ? '0 : gb_cnt_q + GB_CNT_W'(1);
    if (state_d == S_RUN) begin
      am_cnt_d  = am_wrap ? '0 : am_cnt_q + AM_CNT_W'(1);
      am_pend_d = am_wrap;
    end
    if (state_d == S_AM)
      am_pend_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q   <= S_INIT;
      am_cnt_q  <= '0;
      gb_cnt_q  <= '0;
      am_pend_q <= 1'b0;
      blk_q     <= 1'b0;
      am_q      <= 1'b0;
      stall_q   <= 1'b0;
    end else if (en_i) begin
      state_q   <= state_d;
      am_cnt_q  <= am_cnt_d;
      gb_cnt_q  <= gb_cnt_d;
      am_pend_q <= am_pend_d;
      blk_q     <= state_d == S_RUN;
      am_q      <= state_d == S_AM;
      stall_q   <= state_d == S_STALL;
    end else begin
      blk_q     <= 1'b0;
      am_q      <= 1'b0;
      stall_q   <= 1'b0;
    end
  end

  assign ready_o    = blk_q;
  assign blk_v_o    = blk_q;
  assign am_v_o     = am_q;
  assign gb_stall_o = stall_q;

`ifdef PCS_SCHED_DBG_EN
  logic [31:0] am_sent_q, gb_slip_q;

  always_ff @(posedge clk) begin
    if (!nreset) begin
      am_sent_q <= '0;
      gb_slip_q <= '0;
    end else if (en_i) begin
      if (state_d == S_AM && am_sent_q != '1)
        am_sent_q <= am_sent_q + 32'd1;
      if (state_d == S_STALL && gb_slip_q != '1)
        gb_slip_q <= gb_slip_q + 32'd1;
    end
  end

  assign am_sent_o = am_sent_q;
  assign gb_slip_o = gb_slip_q;

  a_onehot: assert property (@(posedge clk)
    $onehot0({blk_q, am_q, stall_q}));
`endif

endmodule

// File: tb/tb_pcs_40g_tx_sched.sv
// Bench for pcs_40g_tx_sched: three instances (8/4, 7/4, 16383/32)
// checked against a count-based slot model.
module tb_pcs_40g_tx_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] nrst = '0;
  logic [2:0] en   = '0;
  logic [2:0] rdy, blk, am, st;
`ifdef PCS_SCHED_DBG_EN
  logic [31:0] am_sent [3];
  logic [31:0] gb_slip [3];
`endif

  int checks   = 0;
  int failures = 0;

  localparam logic [2:0] NO_S  = 3'b000;
  localparam logic [2:0] RUN_S = 3'b100;
  localparam logic [2:0] AM_S  = 3'b010;
  localparam logic [2:0] ST_S  = 3'b001;

  int amp [3] = '{8, 7, 16383};
  int gbp [3] = '{4, 4, 32};

  bit         m_init [3];
  int         m_ss   [3];
  int         m_sa   [3];
  logic [2:0] m_exp  [3];

  pcs_40g_tx_sched #(.AM_PERIOD(8), .GB_PERIOD(4)) u0 (
    .clk(clk), .nreset(nrst[0]), .en_i(en[0]),
    .ready_o(rdy[0]), .blk_v_o(blk[0]),
    .am_v_o(am[0]), .gb_stall_o(st[0])
`ifdef PCS_SCHED_DBG_EN
    , .am_sent_o(am_sent[0]), .gb_slip_o(gb_slip[0])
`endif
  );

  pcs_40g_tx_sched #(.AM_PERIOD(7), .GB_PERIOD(4)) u1 (
    .clk(clk), .nreset(nrst[1]), .en_i(en[1]),
    .ready_o(rdy[1]), .blk_v_o(blk[1]),
    .am_v_o(am[1]), .gb_stall_o(st[1])
`ifdef PCS_SCHED_DBG_EN
    , .am_sent_o(am_sent[1]), .gb_slip_o(gb_slip[1])
`endif
  );

  pcs_40g_tx_sched #(.AM_PERIOD(16383), .GB_PERIOD(32)) u2 (
    .clk(clk), .nreset(nrst[2]), .en_i(en[2]),
    .ready_o(rdy[2]), .blk_v_o(blk[2]),
    .am_v_o(am[2]), .gb_stall_o(st[2])
`ifdef PCS_SCHED_DBG_EN
    , .am_sent_o(am_sent[2]), .gb_slip_o(gb_slip[2])
`endif
  );

  function automatic logic [3:0] obs(input int k);
    return {blk[k], am[k], st[k], rdy[k]};
  endfunction

  function automatic logic [3:0] want(input logic [2:0] s);
    return {s, s[2]};
  endfunction

  function automatic logic [2:0] slot_of(input byte c);
    if (c == "A") return AM_S;
    if (c == "D") return RUN_S;
    if (c == "S") return ST_S;
    return NO_S;
  endfunction

  // Slot rules from counts: blocks since last stall, data since last AM.
  task automatic model_edge(input int k, input bit n, input bit e);
    logic [2:0] s;
    nrst[k] = n;
    en[k]   = e;
    @(posedge clk);
    if (!n) begin
      m_init[k] = 1'b1;
      m_ss[k]   = 0;
      m_sa[k]   = 0;
      m_exp[k]  = NO_S;
    end else if (!e) begin
      m_exp[k] = NO_S;
    end else begin
      if (m_init[k])              s = AM_S;
      else if (m_ss[k] == gbp[k]) s = ST_S;
      else if (m_sa[k] == amp[k]) s = AM_S;
      else                        s = RUN_S;
      m_init[k] = 1'b0;
      if (s == ST_S) m_ss[k] = 0;
      else           m_ss[k]++;
      if (s == AM_S)       m_sa[k] = 0;
      else if (s == RUN_S) m_sa[k]++;
      m_exp[k] = s;
    end
    #1;
  endtask

  task automatic test_reset();
    string seq = "ADDDSDDDDSDA";
    model_edge(0, 1'b0, 1'b1);
    model_edge(0, 1'b0, 1'b1);
    checks++;
    if (obs(0) !== 4'b0000) begin
      failures++;
      $display("FAIL reset: got %b want 0000", obs(0));
    end
    for (int i = 0; i < 12; i++) begin
      model_edge(0, 1'b1, 1'b1);
      checks++;
      if (obs(0) !== want(slot_of(seq[i]))) begin
        failures++;
        $display("FAIL startup c%0d: got %b want %b",
                 i + 1, obs(0), want(slot_of(seq[i])));
      end
    end
  endtask

  task automatic test_collision();
    string seq = "ADDDSDDDDSAD";
    model_edge(1, 1'b0, 1'b1);
    for (int i = 0; i < 12; i++) begin
      model_edge(1, 1'b1, 1'b1);
      checks++;
      if (obs(1) !== want(slot_of(seq[i]))) begin
        failures++;
        $display("FAIL collision c%0d: got %b want %b",
                 i + 1, obs(1), want(slot_of(seq[i])));
      end
    end
  endtask

  task automatic test_freeze();
    int n = 0;
    model_edge(0, 1'b0, 1'b1);
    do begin
      model_edge(0, 1'b1, 1'b1);
      n++;
      checks++;
      if (obs(0) !== want(m_exp[0])) begin
        failures++;
        $display("FAIL freeze_pre: got %b want %b", obs(0), want(m_exp[0]));
      end
    end while (!(!m_init[0] && m_ss[0] != gbp[0] && m_sa[0] == amp[0]) &&
               n < 100);
    checks++;
    if (n >= 100) begin
      failures++;
      $display("FAIL freeze_reach: got %0d cycles want <100", n);
    end
    for (int i = 0; i < 3; i++) begin
      model_edge(0, 1'b1, 1'b0);
      checks++;
      if (obs(0) !== 4'b0000) begin
        failures++;
        $display("FAIL freeze_idle%0d: got %b want 0000", i, obs(0));
      end
    end
    model_edge(0, 1'b1, 1'b1);
    checks++;
    if (obs(0) !== want(AM_S)) begin
      failures++;
      $display("FAIL freeze_am: got %b want %b", obs(0), want(AM_S));
    end
    for (int i = 0; i < 30; i++) begin
      model_edge(0, 1'b1, 1'b1);
      checks++;
      if (obs(0) !== want(m_exp[0])) begin
        failures++;
        $display("FAIL freeze_post%0d: got %b want %b",
                 i, obs(0), want(m_exp[0]));
      end
    end
  endtask

  task automatic test_mid_reset();
    string seq = "ADDDSDDDDSDA";
    int n = 0;
    model_edge(0, 1'b0, 1'b1);
    do begin
      model_edge(0, 1'b1, 1'b1);
      n++;
    end while (!(m_exp[0] == RUN_S && m_sa[0] == 5) && n < 100);
    model_edge(0, 1'b0, 1'b1);
    checks++;
    if (obs(0) !== 4'b0000) begin
      failures++;
      $display("FAIL midrst_zero: got %b want 0000", obs(0));
    end
    for (int i = 0; i < 12; i++) begin
      model_edge(0, 1'b1, 1'b1);
      checks++;
      if (obs(0) !== want(slot_of(seq[i]))) begin
        failures++;
        $display("FAIL midrst c%0d: got %b want %b",
                 i + 1, obs(0), want(slot_of(seq[i])));
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 2; k++) begin
      model_edge(k, 1'b0, 1'b1);
      for (int i = 0; i < 600; i++) begin
        model_edge(k, $urandom_range(0, 99) != 0,
                   $urandom_range(0, 99) < 75);
        checks++;
        if (obs(k) !== want(m_exp[k])) begin
          failures++;
          $display("FAIL random u%0d cyc%0d: got %b want %b",
                   k, i, obs(k), want(m_exp[k]));
        end
      end
    end
  endtask

  task automatic test_long_run();
    int since_am = 0;
    int since_st = 0;
    int n_am = 0;
    int n_st = 0;
    bit first = 1'b1;
    model_edge(2, 1'b0, 1'b1);
    for (int i = 0; i < 55000; i++) begin
      model_edge(2, 1'b1, $urandom_range(0, 999) != 0);
      checks++;
      if (obs(2) !== want(m_exp[2])) begin
        failures++;
        $display("FAIL long cyc%0d: got %b want %b",
                 i, obs(2), want(m_exp[2]));
      end
      if (am[2] === 1'b1) begin
        if (!first) begin
          checks++;
          if (since_am != 16383) begin
            failures++;
            $display("FAIL long_am_gap: got %0d want 16383", since_am);
          end
        end
        first = 1'b0;
        since_am = 0;
        since_st++;
        n_am++;
      end else if (st[2] === 1'b1) begin
        checks++;
        if (since_st != 32) begin
          failures++;
          $display("FAIL long_st_gap: got %0d want 32", since_st);
        end
        since_st = 0;
        n_st++;
      end else if (blk[2] === 1'b1) begin
        since_am++;
        since_st++;
      end
    end
    checks++;
    if (n_am < 3) begin
      failures++;
      $display("FAIL long_am_count: got %0d want >=3", n_am);
    end
`ifdef PCS_SCHED_DBG_EN
    checks++;
    if (am_sent[2] !== 32'(n_am)) begin
      failures++;
      $display("FAIL dbg_am_sent: got %0d want %0d", am_sent[2], n_am);
    end
    checks++;
    if (gb_slip[2] !== 32'(n_st)) begin
      failures++;
      $display("FAIL dbg_gb_slip: got %0d want %0d", gb_slip[2], n_st);
    end
`endif
  endtask

  initial begin
    #1;
    test_reset();
    test_collision();
    test_freeze();
    test_mid_reset();
    test_random();
    test_long_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
